tile_loop_counter: RTL and testbench
====================================

# tile_loop_counter

- Parametrised multi-level nested loop counter that generates tile/row/column/k indices for the systolic array controller.
- Successor to the single 2-bit compare counter.
- Each level counts 0..max inclusive with its own programmable bound, and wraps with carry into the next level.
- A start/busy/done handshake frames one full sweep of the loop nest.

## Interface
Parameters:
- WIDTH, 8, bit width of each level's index and bound
- LEVELS, 3, number of nested levels; level 0 is innermost (fastest)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- cfg_max  input  LEVELS*WIDTH  per-level inclusive bound; level i in bits [i*WIDTH +: WIDTH]; sampled only on accepted start
- start  input  1  begin a sweep; accepted only when busy=0
- clear  input  1  synchronous abort to idle
- inc  input  1  advance the nest by one step; ignored unless busy=1
- busy  output  1  sweep in progress
- done  output  1  single-cycle pulse after the final step of a sweep
- value  output  LEVELS*WIDTH  current indices, same packing as cfg_max
- is_max  output  LEVELS  level i index equals its latched bound (gated by busy)
- last  output  1  all levels at max; the next accepted inc completes the sweep

## Operation
States:
- IDLE: busy=0.
- RUN: busy=1.

Transitions:
- IDLE -> RUN on start=1 and clear=0.
  - cfg_max is latched into shadow bounds.
  - All value fields are set to 0.
- RUN on inc=1:
  - Level 0 increments.
  - Level i wraps to 0 when it is at its bound and receives carry; the carry then propagates to level i+1.
  - Level i holds when it receives no carry.
- RUN, inc=1 and last=1 (final step):
  - All value fields return to 0.
  - done pulses.
  - State goes to IDLE.
- RUN, inc=0: all state holds.
- Any state, clear=1:
  - Next state IDLE, value=0.
  - No done pulse.
  - Shadow bounds are unchanged.

Rules:
- Arithmetic is unsigned, modulo 2^WIDTH per level.
- Bound 0 gives one iteration for that level.
- Bound 2^WIDTH-1 gives the full range with no overflow beyond the wrap.
- One sweep is exactly prod(max_i+1) accepted incs.
- is_max[i] = busy & (value_i == shadow_max_i).
- last = &is_max.
- is_max and last are combinational from registers only; they have no input-to-output paths.

Boundary behaviour:
- start while busy=1 is ignored; shadow bounds are not reloaded.
- start and inc in the same IDLE cycle: inc is ignored, and value is 0 after the edge.
- clear and start in the same cycle: clear wins and the block remains IDLE.
- clear and inc in the same cycle: clear wins.
- Reset mid-sweep: immediate return to IDLE with all outputs at reset values; no done pulse.
- Changing cfg_max during RUN has no effect.

## Timing
- Reset values:
  - busy=0, done=0, value=0, is_max=0, last=0.
  - Shadow bounds = 0.
  - State IDLE.
- Start accepted at edge n: busy=1 and value=0 are visible after edge n.
- One accepted inc at edge n: new value is visible after edge n (1-cycle latency); is_max and last update in the same cycle.
- Final inc at edge n:
  - After edge n: done=1, busy=0, value=0.
  - After edge n+1: done=0.
- Earliest restart: start may be asserted in the cycle done=1 and is accepted at edge n+1.
- Back-to-back incs every cycle are supported; there is no bubble at wrap points.

## Configuration
- TILE_LOOP_AUTO_RESTART_EN defined:
  - On the final step, done still pulses for one cycle.
  - State stays RUN and busy stays 1.
  - Value returns to 0 and the same shadow bounds are reused; the sweep repeats until clear or reset.
  - start during RUN remains ignored.
- Not defined: the final step returns to IDLE as described in Operation.

## Test plan
All tests use WIDTH=8, LEVELS=3 unless stated.
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-sweep at value {1,2,1} (level2,1,0); pulse inc while idle.
  - Response: immediately busy=0, value=0, is_max=0, done=0; inc while idle leaves value at 0.
- Full sweep:
  - Stimulus: cfg_max={1,2,3}, start, then inc every cycle.
  - Response:
    - Level0 sequence 0,1,2,3,0; level1 advances on level0 wrap.
    - last=1 only at {1,2,3}.
    - done pulses exactly once after the 24th inc, with busy=0 and value=0 in that cycle.
- Stalls and bounds of 0:
  - Stimulus: cfg_max={0,0,2}, inc asserted every other cycle.
  - Response: value holds on inc=0 cycles; done follows the 3rd accepted inc; is_max[2:1]=2'b11 throughout RUN.
- Simultaneous controls:
  - Stimulus: start+clear in the same cycle; then start+inc in IDLE; then start during RUN with different cfg_max.
  - Response: first stays IDLE; second gives value=0 after the edge; third gives no reload (sweep length unchanged).
- Width extremes:
  - Stimulus: WIDTH=2, LEVELS=1, cfg_max=3, 4 incs.
  - Response: value 0,1,2,3, then done with value=0; is_max matches the single-counter compare behaviour.
- Auto-restart (TILE_LOOP_AUTO_RESTART_EN):
  - Stimulus: cfg_max={0,0,1}, 6 incs, then clear.
  - Response: done pulses after incs 2, 4 and 6; busy stays 1 until clear; after clear busy=0.

Source files
------------

// File: rtl/tile_loop_counter.sv
// tile_loop_counter: nested multi-level loop index generator for the systolic array controller.
// Each of LEVELS levels counts 0..bound inclusive and carries into the next level on wrap.
// A start/busy/done handshake frames one full sweep of the loop nest.
// Optional feature: define TILE_LOOP_AUTO_RESTART_EN to repeat the sweep on its final step
// instead of returning to idle.
module tile_loop_counter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LEVELS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LEVELS*WIDTH-1:0]   cfg_max,
    input  logic                      start,
    input  logic                      clear,
    input  logic                      inc,
    output logic                      busy,
    output logic                      done,
    output logic [LEVELS*WIDTH-1:0]   value,
    output logic [LEVELS-1:0]         is_max,
    output logic                      last
);

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    logic                    state_q, state_d;
    logic [LEVELS*WIDTH-1:0] shadow_q, shadow_d;
    logic [LEVELS*WIDTH-1:0] value_q, value_d;
    logic                    done_q, done_d;

    logic [LEVELS-1:0]       at_max;
    logic [LEVELS*WIDTH-1:0] value_step;
    logic                    carry;
    logic                    final_step;

    // Per-level compare of the registered index against the latched bound.
    always_comb begin
        at_max = '0;
        for (int i = 0; i < LEVELS; i++) begin
            at_max[i] = (value_q[i*WIDTH +: WIDTH] == shadow_q[i*WIDTH +: WIDTH]);
        end
    end

    assign busy       = (state_q == StRun);
    assign is_max     = busy ? at_max : '0;
    assign last       = &is_max;
    assign done       = done_q;
    assign value      = value_q;
    assign final_step = busy & inc & last;

    // Ripple carry through the levels: a level advances only if every inner level is at its bound.
    always_comb begin
        value_step = value_q;
        carry      = 1'b1;
        for (int i = 0; i < LEVELS; i++) begin
            if (carry) begin
                if (at_max[i]) begin
                    value_step[i*WIDTH +: WIDTH] = '0;
                end else begin
                    value_step[i*WIDTH +: WIDTH] = value_q[i*WIDTH +: WIDTH] + WIDTH'(1);
                end
            end
            carry = carry & at_max[i];
        end
    end

    // Next-state logic: clear dominates, then start in idle, then stepping in run.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        value_d  = value_q;
        done_d   = 1'b0;
        if (clear) begin
            state_d = StIdle;
            value_d = '0;
        end else if (state_q == StIdle) begin
            if (start) begin
                state_d  = StRun;
                shadow_d = cfg_max;
                value_d  = '0;
            end
        end else if (inc) begin
            if (final_step) begin
                done_d  = 1'b1;
                value_d = '0;
`ifdef TILE_LOOP_AUTO_RESTART_EN
                state_d = StRun;
`else
                state_d = StIdle;
`endif
            end else begin
                value_d = value_step;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            value_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            value_q  <= value_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_tile_loop_counter.sv
// Self-checking bench for tile_loop_counter: a WIDTH=8/LEVELS=3 instance and a WIDTH=2/LEVELS=1
// instance. Honours TILE_LOOP_AUTO_RESTART_EN when defined.
module tb_tile_loop_counter;

`ifdef TILE_LOOP_AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] cfg_max = '0;
    logic        start = 1'b0, clear = 1'b0, inc = 1'b0;
    logic        busy, done, last;
    logic [23:0] value;
    logic [2:0]  is_max;

    logic [1:0]  n_cfg = '0;
    logic        n_start = 1'b0, n_clear = 1'b0, n_inc = 1'b0;
    logic        n_busy, n_done, n_last;
    logic [1:0]  n_value;
    logic [0:0]  n_is_max;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tile_loop_counter #(.WIDTH(8), .LEVELS(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_max(cfg_max), .start(start), .clear(clear), .inc(inc),
        .busy(busy), .done(done), .value(value), .is_max(is_max), .last(last)
    );

    tile_loop_counter #(.WIDTH(2), .LEVELS(1)) u_narrow (
        .clk(clk), .rst_n(rst_n), .cfg_max(n_cfg), .start(n_start), .clear(n_clear),
        .inc(n_inc), .busy(n_busy), .done(n_done), .value(n_value), .is_max(n_is_max),
        .last(n_last)
    );

    typedef struct {
        logic        start;
        logic        clear;
        logic        inc;
        logic [23:0] cfg;
        logic        busy;
        logic        done;
        logic [23:0] value;
        logic [2:0]  is_max;
        logic        last;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic e_busy, input logic e_done,
                              input logic [23:0] e_value, input logic [2:0] e_is_max,
                              input logic e_last);
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".done"}, 32'(done), 32'(e_done));
        check({tag, ".value"}, 32'(value), 32'(e_value));
        check({tag, ".is_max"}, 32'(is_max), 32'(e_is_max));
        check({tag, ".last"}, 32'(last), 32'(e_last));
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[13];
        logic [23:0] ev;
        logic [2:0]  em;

        vecs[0]  = '{1, 1, 0, 24'h000001, 0, 0, 24'h000000, 3'b000, 0}; // start+clear: stay idle
        vecs[1]  = '{1, 0, 1, 24'h000001, 1, 0, 24'h000000, 3'b110, 0}; // start+inc: value 0
        vecs[2]  = '{1, 0, 0, 24'h000005, 1, 0, 24'h000000, 3'b110, 0}; // start in run ignored
        vecs[3]  = '{0, 0, 1, 24'h000005, 1, 0, 24'h000001, 3'b111, 1}; // old bound still used
        vecs[4]  = '{0, 0, 1, 24'h000005, 0, 1, 24'h000000, 3'b000, 0}; // final step
        vecs[5]  = '{0, 0, 0, 24'h000005, 0, 0, 24'h000000, 3'b000, 0}; // done drops
        vecs[6]  = '{1, 0, 0, 24'h000001, 1, 0, 24'h000000, 3'b110, 0};
        vecs[7]  = '{0, 1, 1, 24'h000001, 0, 0, 24'h000000, 3'b000, 0}; // clear beats inc
        vecs[8]  = '{1, 0, 0, 24'h020000, 1, 0, 24'h000000, 3'b011, 0};
        vecs[9]  = '{0, 0, 1, 24'h000000, 1, 0, 24'h010000, 3'b011, 0}; // carry to level 2
        vecs[10] = '{0, 0, 1, 24'h000000, 1, 0, 24'h020000, 3'b111, 1};
        vecs[11] = '{0, 0, 0, 24'h000000, 1, 0, 24'h020000, 3'b111, 1}; // stall holds
        vecs[12] = '{0, 0, 1, 24'h000000, 0, 1, 24'h000000, 3'b000, 0};

        // Reset state
        step();
        step();
        check_main("reset", 0, 0, 24'h0, 3'b000, 0);
        check("reset.n_busy", 32'(n_busy), 32'd0);
        rst_n = 1'b1;
        step();

        // Reset mid-sweep at {1,2,1}
        cfg_max = {8'd1, 8'd2, 8'd3};
        start = 1'b1;
        step();
        start = 1'b0;
        inc = 1'b1;
        for (int k = 0; k < 21; k++) step();
        check("midsweep.value", 32'(value), 32'h010201);
        #2;
        rst_n = 1'b0;
        #1;
        check_main("async_reset", 0, 0, 24'h0, 3'b000, 0);
        step();
        rst_n = 1'b1;
        step();
        check_main("idle_inc", 0, 0, 24'h0, 3'b000, 0);
        inc = 1'b0;

        // Full sweep {1,2,3}
        cfg_max = {8'd1, 8'd2, 8'd3};
        start = 1'b1;
        step();
        start = 1'b0;
        check_main("sweep.start", 1, 0, 24'h0, 3'b000, 0);
        inc = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k < 24) begin
                ev = {8'(k / 12), 8'((k / 4) % 3), 8'(k % 4)};
                em = {(k / 12) == 1, ((k / 4) % 3) == 2, (k % 4) == 3};
                check_main($sformatf("sweep.k%0d", k), 1, 0, ev, em, k == 23);
            end else begin
                check_main("sweep.final", AUTO, 1, 24'h0, 3'b000, 0);
            end
        end
        inc = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_main("sweep.after", 0, 0, 24'h0, 3'b000, 0);

        // Stalls with zero bounds {0,0,2}
        cfg_max = {8'd0, 8'd0, 8'd2};
        start = 1'b1;
        step();
        start = 1'b0;
        check_main("stall.start", 1, 0, 24'h0, 3'b110, 0);
        for (int k = 1; k <= 3; k++) begin
            inc = 1'b0;
            step();
            check_main($sformatf("stall.hold%0d", k), 1, 0, 24'(k - 1), (k == 3) ? 3'b111 : 3'b110,
                       k == 3);
            inc = 1'b1;
            step();
            if (k < 3) begin
                check_main($sformatf("stall.inc%0d", k), 1, 0, 24'(k), (k == 2) ? 3'b111 : 3'b110,
                           k == 2);
            end else begin
                check_main("stall.final", AUTO, 1, 24'h0, AUTO ? 3'b110 : 3'b000, 0);
            end
        end
        inc = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;

`ifndef TILE_LOOP_AUTO_RESTART_EN
        // Simultaneous controls, table driven
        for (int v = 0; v < 13; v++) begin
            start   = vecs[v].start;
            clear   = vecs[v].clear;
            inc     = vecs[v].inc;
            cfg_max = vecs[v].cfg;
            step();
            check_main($sformatf("vec%0d", v), vecs[v].busy, vecs[v].done, vecs[v].value,
                       vecs[v].is_max, vecs[v].last);
        end
        start = 1'b0;
        clear = 1'b0;
        inc   = 1'b0;
`else
        // Auto-restart: {0,0,1}, six incs then clear
        cfg_max = {8'd0, 8'd0, 8'd1};
        start = 1'b1;
        step();
        start = 1'b0;
        inc = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k % 2 == 0) begin
                check_main($sformatf("auto.k%0d", k), 1, 1, 24'h0, 3'b110, 0);
            end else begin
                check_main($sformatf("auto.k%0d", k), 1, 0, 24'h1, 3'b111, 1);
            end
        end
        inc = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_main("auto.clear", 0, 0, 24'h0, 3'b000, 0);
`endif

        // Narrow instance: WIDTH=2, LEVELS=1, bound 3
        n_cfg = 2'd3;
        n_start = 1'b1;
        step();
        n_start = 1'b0;
        check("narrow.start.value", 32'(n_value), 32'd0);
        check("narrow.start.busy", 32'(n_busy), 32'd1);
        n_inc = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4) begin
                check($sformatf("narrow.k%0d.value", k), 32'(n_value), 32'(k));
                check($sformatf("narrow.k%0d.is_max", k), 32'(n_is_max), 32'(k == 3));
                check($sformatf("narrow.k%0d.last", k), 32'(n_last), 32'(k == 3));
                check($sformatf("narrow.k%0d.done", k), 32'(n_done), 32'd0);
            end else begin
                check("narrow.final.value", 32'(n_value), 32'd0);
                check("narrow.final.done", 32'(n_done), 32'd1);
                check("narrow.final.busy", 32'(n_busy), 32'(AUTO));
                check("narrow.final.is_max", 32'(n_is_max), 32'd0);
            end
        end
        n_inc = 1'b0;
        step();
        check("narrow.after.done", 32'(n_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
